// File: rtl/rubytop_l1d_ld_replay_q_pkg.sv
// Shared types for the L1D load replay queue: LSU/L1D request and response
// payloads, the replay-entry state enum, the stored entry record and small
// conversion helpers.
package rubytop_l1d_ld_replay_q_pkg;

   localparam int RRV64_LSU_ID_W   = 5;
   localparam int RRV64_PADDR_W    = 40;
   localparam int RRV64_L1D_MSHR_D = 4;
   localparam int RRV64_MSHR_ID_W  = $clog2(RRV64_L1D_MSHR_D);

   typedef enum logic [5:0] {
      LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW, LSU_LWU, LSU_LD,
      LSU_SB, LSU_SH, LSU_SW, LSU_SD,
      LSU_LRW, LSU_LRD, LSU_SCW, LSU_SCD,
      LSU_AMOSWAPW, LSU_AMOSWAPD, LSU_AMOADDW, LSU_AMOADDD,
      LSU_AMOANDW, LSU_AMOANDD, LSU_AMOORW, LSU_AMOORD,
      LSU_AMOXORW, LSU_AMOXORD, LSU_AMOMAXW, LSU_AMOMAXD,
      LSU_AMOMAXUW, LSU_AMOMAXUD, LSU_AMOMINW, LSU_AMOMIND,
      LSU_AMOMINUW, LSU_AMOMINUD
   } rrv64_lsu_req_type_e;

   typedef enum logic [2:0] {
      LDRQ_FREE, LDRQ_WAIT, LDRQ_SENT, LDRQ_IDMISS,
      LDRQ_FULLMISS, LDRQ_PENDING, LDRQ_FLUSHED
   } ldrq_state_e;

   typedef struct packed {
      logic [RRV64_LSU_ID_W-1:0] lsu_id;
      logic [RRV64_PADDR_W-1:0]  paddr;
      rrv64_lsu_req_type_e       req_type;
      logic                      is_cacheable;
   } rrv64_lsu_l1d_req_t;

   typedef struct packed {
      logic [RRV64_LSU_ID_W-1:0] lsu_id;
      rrv64_lsu_req_type_e       req_type;
      logic [63:0]               ld_data;
   } rrv64_lsu_l1d_resp_t;

   typedef struct packed {
      logic [RRV64_LSU_ID_W-1:0]  lsu_id;
      logic [RRV64_PADDR_W-1:0]   paddr;
      rrv64_lsu_req_type_e        req_type;
      logic                       is_cacheable;
      logic [RRV64_MSHR_ID_W-1:0] mshr_id;
   } ldrq_entry_t;

   // AMO and LR/SC responses belong to another path and never match a load
   function automatic logic is_amo_lrsc(rrv64_lsu_req_type_e t);
      return (t >= LSU_LRW) && (t <= LSU_AMOMINUD);
   endfunction

   function automatic rrv64_lsu_l1d_req_t ent2req(ldrq_entry_t e);
      rrv64_lsu_l1d_req_t r;
      r.lsu_id       = e.lsu_id;
      r.paddr        = e.paddr;
      r.req_type     = e.req_type;
      r.is_cacheable = e.is_cacheable;
      return r;
   endfunction

endpackage

// File: rtl/rubytop_l1d_ld_replay_q_if.sv
// LSU / L1D / MSHR-wakeup bundle for the load replay queue.
// slave  : replay queue side (LSU request in, L1D request out, L1D response,
//          sleep and wakeup in, LSU response and occupancy out).
// master : environment side (LSU + L1D model).
interface rubytop_l1d_ld_replay_q_if
   import rubytop_l1d_ld_replay_q_pkg::*;
#(
   parameter int ENTRY_NUM = 32,
   parameter int LSU_ID_W  = RRV64_LSU_ID_W,
   parameter int MSHR_ID_W = RRV64_MSHR_ID_W
) ();
   logic                         core_req_valid_i;
   rrv64_lsu_l1d_req_t           core_req_i;
   logic                         core_req_ready_o;
   logic                         core_resp_valid_o;
   rrv64_lsu_l1d_resp_t          core_resp_o;
   logic                         l1d_req_valid_o;
   rrv64_lsu_l1d_req_t           l1d_req_o;
   logic                         l1d_req_ready_i;
   logic                         l1d_resp_valid_i;
   rrv64_lsu_l1d_resp_t          l1d_resp_i;
   logic                         sleep_valid_i;
   logic [LSU_ID_W-1:0]          sleep_lsu_id_i;
   logic                         sleep_mshr_full_i;
   logic [MSHR_ID_W-1:0]         sleep_mshr_id_i;
   logic                         wakeup_refill_valid_i;
   logic [MSHR_ID_W-1:0]         wakeup_mshr_id_i;
   logic                         wakeup_mshr_avail_i;
   logic                         flush_i;
   logic [$clog2(ENTRY_NUM):0]   occupancy_o;

   modport slave (
      input  core_req_valid_i, core_req_i, l1d_req_ready_i, l1d_resp_valid_i,
             l1d_resp_i, sleep_valid_i, sleep_lsu_id_i, sleep_mshr_full_i,
             sleep_mshr_id_i, wakeup_refill_valid_i, wakeup_mshr_id_i,
             wakeup_mshr_avail_i, flush_i,
      output core_req_ready_o, core_resp_valid_o, core_resp_o,
             l1d_req_valid_o, l1d_req_o, occupancy_o
   );

   modport master (
      output core_req_valid_i, core_req_i, l1d_req_ready_i, l1d_resp_valid_i,
             l1d_resp_i, sleep_valid_i, sleep_lsu_id_i, sleep_mshr_full_i,
             sleep_mshr_id_i, wakeup_refill_valid_i, wakeup_mshr_id_i,
             wakeup_mshr_avail_i, flush_i,
      input  core_req_ready_o, core_resp_valid_o, core_resp_o,
             l1d_req_valid_o, l1d_req_o, occupancy_o
   );
endinterface

// File: rtl/rubytop_l1d_ld_replay_q_one_hot_age_oldest.sv
// Age matrix for N entries plus oldest-of-mask select.
// r_age[i][j] = 1 means entry j is older than entry i. Rows are written on
// allocation only, so ordering never wraps.
// Ports: i_alloc/i_alloc_oh  allocation strobe and one-hot slot
//        i_live_mask         entries currently occupied
//        i_req_mask          candidate entries
//        o_oldest_oh         one-hot oldest candidate (0 if none)
module rubytop_l1d_ld_replay_q_one_hot_age_oldest #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_alloc,
   input  logic [N-1:0] i_alloc_oh,
   input  logic [N-1:0] i_live_mask,
   input  logic [N-1:0] i_req_mask,
   output logic [N-1:0] o_oldest_oh
);
   logic [N-1:0] r_age [N];

   // Stale bits pointing at freed entries are harmless: selection only looks
   // at columns inside i_req_mask, and a column is cleared on reallocation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) r_age[i] <= '0;
      end else if (i_alloc) begin
         for (int i = 0; i < N; i++) begin
            if (i_alloc_oh[i]) r_age[i] <= i_live_mask;
            else               r_age[i] <= r_age[i] & ~i_alloc_oh;
         end
      end
   end

   always_comb begin
      o_oldest_oh = '0;
      for (int i = 0; i < N; i++)
         o_oldest_oh[i] = i_req_mask[i] & ~(|(r_age[i] & i_req_mask));
   end
endmodule

// File: rtl/rubytop_l1d_ld_replay_q.sv
// Load replay queue between the LSU load port and the L1D load pipe.
// Tracks in-flight loads per entry, holds the L1D request under backpressure,
// parks loads put to sleep by the L1D and replays them oldest-first.
// Ports: clk, rst_n (async active-low), bus (slave modport: LSU request and
//        response, L1D request and response, sleep, wakeup, flush, occupancy).
//
// state    | meaning
// FREE     | slot unused
// WAIT     | presented to the L1D, not yet accepted (at most one)
// SENT     | accepted by the L1D, awaiting response or sleep
// IDMISS   | parked on the miss tracked by mshr_id
// FULLMISS | parked on MSHR-full
// PENDING  | woken, waiting to be reissued
// FLUSHED  | in flight across a flush; its response is dropped
module rubytop_l1d_ld_replay_q
   import rubytop_l1d_ld_replay_q_pkg::*;
#(
   parameter int ENTRY_NUM = 32,
   parameter int LSU_ID_W  = RRV64_LSU_ID_W,
   parameter int MSHR_NUM  = RRV64_L1D_MSHR_D,
   localparam int MSHR_ID_W = $clog2(MSHR_NUM),
   localparam int OCC_W     = $clog2(ENTRY_NUM) + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   rubytop_l1d_ld_replay_q_if.slave      bus
);
   ldrq_state_e          r_st [ENTRY_NUM];
   ldrq_state_e          w_st_nxt [ENTRY_NUM];
   ldrq_entry_t          r_ent [ENTRY_NUM];
   logic [ENTRY_NUM-1:0] r_unacc, w_unacc_nxt;
   logic [OCC_W-1:0]     r_occ, w_occ_nxt;

   logic [ENTRY_NUM-1:0] w_free_mask, w_pend_mask, w_flushed_mask;
   logic [ENTRY_NUM-1:0] w_resp_hit, w_sleep_hit, w_alloc_oh, w_pend_oh;
   logic                 w_ready, w_alloc, w_hold_any, w_pend_any, w_pend_go, w_bypass;
   logic                 w_rdy;
   logic [LSU_ID_W-1:0]  w_sleep_id;
   logic [MSHR_ID_W-1:0] w_wake_id;
   rrv64_lsu_l1d_req_t   w_hold_req, w_pend_req, w_l1d_req;

   assign w_sleep_id = bus.sleep_lsu_id_i;
   assign w_wake_id  = bus.wakeup_mshr_id_i;
   assign w_rdy      = bus.l1d_req_ready_i;

   always_comb begin
      w_free_mask    = '0;
      w_pend_mask    = '0;
      w_flushed_mask = '0;
      w_resp_hit     = '0;
      w_sleep_hit    = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_free_mask[i]    = (r_st[i] == LDRQ_FREE);
         w_pend_mask[i]    = (r_st[i] == LDRQ_PENDING);
         w_flushed_mask[i] = (r_st[i] == LDRQ_FLUSHED);
         w_resp_hit[i]  = bus.l1d_resp_valid_i && !is_amo_lrsc(bus.l1d_resp_i.req_type) &&
                          (r_st[i] == LDRQ_SENT || r_st[i] == LDRQ_FLUSHED) && !r_unacc[i] &&
                          (r_ent[i].lsu_id == bus.l1d_resp_i.lsu_id);
         w_sleep_hit[i] = bus.sleep_valid_i &&
                          (r_st[i] == LDRQ_SENT || r_st[i] == LDRQ_FLUSHED) && !r_unacc[i] &&
                          (r_ent[i].lsu_id == w_sleep_id);
      end
   end

   // lowest set bit of the free mask
   assign w_alloc_oh = w_free_mask & (~w_free_mask + ENTRY_NUM'(1));
   assign w_ready    = (|w_free_mask) && !bus.flush_i;
   assign w_alloc    = bus.core_req_valid_i && w_ready;
   assign w_hold_any = |r_unacc;
   assign w_pend_any = |w_pend_mask;
   assign w_pend_go  = !w_hold_any && w_pend_any && !bus.flush_i;
   assign w_bypass   = w_alloc && !w_hold_any && !w_pend_any;

   rubytop_l1d_ld_replay_q_one_hot_age_oldest #(.N(ENTRY_NUM)) u_age (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_alloc     (w_alloc),
      .i_alloc_oh  (w_alloc_oh),
      .i_live_mask (~w_free_mask),
      .i_req_mask  (w_pend_mask),
      .o_oldest_oh (w_pend_oh)
   );

   always_comb begin
      w_hold_req = '0;
      w_pend_req = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (r_unacc[i])   w_hold_req = ent2req(r_ent[i]);
         if (w_pend_oh[i]) w_pend_req = ent2req(r_ent[i]);
      end
      if (w_hold_any)     w_l1d_req = w_hold_req;
      else if (w_pend_go) w_l1d_req = w_pend_req;
      else if (w_bypass)  w_l1d_req = bus.core_req_i;
      else                w_l1d_req = '0;
   end

   assign bus.l1d_req_valid_o   = w_hold_any || w_pend_go || w_bypass;
   assign bus.l1d_req_o         = w_l1d_req;
   assign bus.core_req_ready_o  = w_ready;
   assign bus.core_resp_valid_o = bus.l1d_resp_valid_i && !(|(w_resp_hit & w_flushed_mask));
   assign bus.core_resp_o       = bus.l1d_resp_i;
   assign bus.occupancy_o       = r_occ;

   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_st_nxt[i]    = r_st[i];
         w_unacc_nxt[i] = r_unacc[i];
         case (r_st[i])
            LDRQ_FREE: if (w_alloc && w_alloc_oh[i]) begin
               if (w_bypass) begin
                  w_st_nxt[i]    = w_rdy ? LDRQ_SENT : LDRQ_WAIT;
                  w_unacc_nxt[i] = !w_rdy;
               end else begin
                  w_st_nxt[i] = LDRQ_PENDING;
               end
            end
            LDRQ_WAIT: begin
               if (w_rdy) w_unacc_nxt[i] = 1'b0;
               if (bus.flush_i) w_st_nxt[i] = LDRQ_FLUSHED;
               else if (w_rdy)  w_st_nxt[i] = LDRQ_SENT;
            end
            LDRQ_PENDING: begin
               if (bus.flush_i) w_st_nxt[i] = LDRQ_FREE;
               else if (w_pend_go && w_pend_oh[i]) begin
                  w_st_nxt[i]    = w_rdy ? LDRQ_SENT : LDRQ_WAIT;
                  w_unacc_nxt[i] = !w_rdy;
               end
            end
            LDRQ_SENT: begin
               if (w_resp_hit[i]) w_st_nxt[i] = LDRQ_FREE;
               else if (w_sleep_hit[i]) begin
                  // a wakeup in the same cycle as the sleep skips the parked state
                  if (bus.flush_i)               w_st_nxt[i] = LDRQ_FREE;
                  else if (bus.sleep_mshr_full_i)
                     w_st_nxt[i] = bus.wakeup_mshr_avail_i ? LDRQ_PENDING : LDRQ_FULLMISS;
                  else
                     w_st_nxt[i] = (bus.wakeup_refill_valid_i && bus.sleep_mshr_id_i == w_wake_id) ?
                                   LDRQ_PENDING : LDRQ_IDMISS;
               end else if (bus.flush_i) w_st_nxt[i] = LDRQ_FLUSHED;
            end
            LDRQ_IDMISS: begin
               if (bus.flush_i) w_st_nxt[i] = LDRQ_FREE;
               else if (bus.wakeup_refill_valid_i && r_ent[i].mshr_id == w_wake_id)
                  w_st_nxt[i] = LDRQ_PENDING;
            end
            LDRQ_FULLMISS: begin
               if (bus.flush_i)                  w_st_nxt[i] = LDRQ_FREE;
               else if (bus.wakeup_mshr_avail_i) w_st_nxt[i] = LDRQ_PENDING;
            end
            LDRQ_FLUSHED: begin
               // a flushed WAIT entry keeps presenting until the L1D takes it
               if (r_unacc[i]) begin
                  if (w_rdy) w_unacc_nxt[i] = 1'b0;
               end else if (w_resp_hit[i] || w_sleep_hit[i]) begin
                  w_st_nxt[i] = LDRQ_FREE;
               end
            end
            default: w_st_nxt[i] = LDRQ_FREE;
         endcase
      end
   end

   always_comb begin
      w_occ_nxt = '0;
      for (int i = 0; i < ENTRY_NUM; i++)
         w_occ_nxt = w_occ_nxt + OCC_W'(w_st_nxt[i] != LDRQ_FREE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRY_NUM; i++) r_st[i] <= LDRQ_FREE;
         r_unacc <= '0;
         r_occ   <= '0;
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) r_st[i] <= w_st_nxt[i];
         r_unacc <= w_unacc_nxt;
         r_occ   <= w_occ_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRY_NUM; i++) r_ent[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (w_alloc && w_alloc_oh[i]) begin
               r_ent[i].lsu_id       <= bus.core_req_i.lsu_id;
               r_ent[i].paddr        <= bus.core_req_i.paddr;
               r_ent[i].req_type     <= bus.core_req_i.req_type;
               r_ent[i].is_cacheable <= bus.core_req_i.is_cacheable;
               r_ent[i].mshr_id      <= '0;
            end else if (w_sleep_hit[i] && !bus.sleep_mshr_full_i) begin
               r_ent[i].mshr_id <= bus.sleep_mshr_id_i;
            end
         end
      end
   end
endmodule

// File: tb/tb_rubytop_l1d_ld_replay_q.sv
module tb_rubytop_l1d_ld_replay_q;
   import rubytop_l1d_ld_replay_q_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rubytop_l1d_ld_replay_q_if #(.ENTRY_NUM(32)) bus ();
   rubytop_l1d_ld_replay_q #(.ENTRY_NUM(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int nvec  = 0;
   int nfail = 0;
   logic [44:0] q_req [$];
   logic [68:0] q_resp [$];

   task automatic chk(string name, logic [68:0] act, logic [68:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every accepted L1D request and every LSU response is popped
   // against the scoreboard queues
   initial begin : mon
      logic [44:0] e_req;
      logic [68:0] e_resp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.l1d_req_valid_o && bus.l1d_req_ready_i) begin
               if (q_req.size() == 0) begin
                  nvec++; nfail++;
                  $display("FAIL l1d_req_unexpected: got id %0d expected none", bus.l1d_req_o.lsu_id);
               end else begin
                  e_req = q_req.pop_front();
                  chk("l1d_req", 69'({bus.l1d_req_o.lsu_id, bus.l1d_req_o.paddr}), 69'(e_req));
               end
            end
            if (bus.core_resp_valid_o) begin
               if (q_resp.size() == 0) begin
                  nvec++; nfail++;
                  $display("FAIL core_resp_unexpected: got id %0d expected none", bus.core_resp_o.lsu_id);
               end else begin
                  e_resp = q_resp.pop_front();
                  chk("core_resp", {bus.core_resp_o.lsu_id, bus.core_resp_o.ld_data}, e_resp);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic req_on(int id, logic [39:0] pa);
      bus.core_req_valid_i         = 1'b1;
      bus.core_req_i.lsu_id        = 5'(id);
      bus.core_req_i.paddr         = pa;
      bus.core_req_i.req_type      = LSU_LD;
      bus.core_req_i.is_cacheable  = 1'b1;
   endtask

   // one-cycle load, expected to bypass and be accepted
   task automatic issue(int id, logic [39:0] pa);
      req_on(id, pa);
      q_req.push_back({5'(id), pa});
      @(negedge clk);
      step();
      bus.core_req_valid_i = 1'b0;
   endtask

   task automatic respond(int id, rrv64_lsu_req_type_e t, bit pass);
      bus.l1d_resp_valid_i    = 1'b1;
      bus.l1d_resp_i.lsu_id   = 5'(id);
      bus.l1d_resp_i.req_type = t;
      bus.l1d_resp_i.ld_data  = 64'hD000_0000 + 64'(id);
      if (pass) q_resp.push_back({5'(id), 64'hD000_0000 + 64'(id)});
      @(negedge clk);
      if (!pass) chk("resp_dropped", 69'(bus.core_resp_valid_o), 69'(0));
      step();
      bus.l1d_resp_valid_i = 1'b0;
   endtask

   task automatic sleep(int id, logic full, logic [1:0] mshr);
      bus.sleep_valid_i     = 1'b1;
      bus.sleep_lsu_id_i    = 5'(id);
      bus.sleep_mshr_full_i = full;
      bus.sleep_mshr_id_i   = mshr;
      @(negedge clk);
      step();
      bus.sleep_valid_i = 1'b0;
   endtask

   initial begin
      bus.core_req_valid_i = 0; bus.core_req_i = '0; bus.l1d_req_ready_i = 0;
      bus.l1d_resp_valid_i = 0; bus.l1d_resp_i = '0; bus.sleep_valid_i = 0;
      bus.sleep_lsu_id_i = '0; bus.sleep_mshr_full_i = 0; bus.sleep_mshr_id_i = '0;
      bus.wakeup_refill_valid_i = 0; bus.wakeup_mshr_id_i = '0;
      bus.wakeup_mshr_avail_i = 0; bus.flush_i = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 69'(bus.core_req_ready_o), 69'(1));
      chk("rst_l1d_valid", 69'(bus.l1d_req_valid_o), 69'(0));
      chk("rst_resp_valid", 69'(bus.core_resp_valid_o), 69'(0));
      chk("rst_occ", 69'(bus.occupancy_o), 69'(0));
      step();

      // bypass with zero latency, response frees the entry
      bus.l1d_req_ready_i = 1'b1;
      req_on(3, 40'h1000);
      q_req.push_back({5'd3, 40'h1000});
      @(negedge clk);
      chk("bypass_same_cycle", 69'(bus.l1d_req_valid_o), 69'(1));
      step();
      bus.core_req_valid_i = 1'b0;
      @(negedge clk);
      chk("occ_after_alloc", 69'(bus.occupancy_o), 69'(1));
      step();
      respond(3, LSU_LD, 1);
      @(negedge clk);
      chk("occ_after_free", 69'(bus.occupancy_o), 69'(0));
      step();

      // backpressure: payload held for 4 cycles, accepted on the 5th
      bus.l1d_req_ready_i = 1'b0;
      req_on(5, 40'h2040);
      q_req.push_back({5'd5, 40'h2040});
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("hold_valid", 69'(bus.l1d_req_valid_o), 69'(1));
         chk("hold_payload", 69'({bus.l1d_req_o.lsu_id, bus.l1d_req_o.paddr}), 69'({5'd5, 40'h2040}));
         step();
         bus.core_req_valid_i = 1'b0;
      end
      bus.l1d_req_ready_i = 1'b1;
      @(negedge clk);
      chk("hold_accept_valid", 69'(bus.l1d_req_valid_o), 69'(1));
      step();
      @(negedge clk);
      chk("sent_no_valid", 69'(bus.l1d_req_valid_o), 69'(0));
      step();
      respond(5, LSU_LD, 1);

      // three loads sleep on MSHR 2, replay oldest-first after refill
      issue(1, 40'h100);
      issue(2, 40'h200);
      issue(4, 40'h400);
      sleep(1, 1'b0, 2'd2);
      sleep(2, 1'b0, 2'd2);
      sleep(4, 1'b0, 2'd2);
      bus.wakeup_refill_valid_i = 1'b1;
      bus.wakeup_mshr_id_i      = 2'd2;
      q_req.push_back({5'd1, 40'h100});
      q_req.push_back({5'd2, 40'h200});
      q_req.push_back({5'd4, 40'h400});
      @(negedge clk);
      chk("replay_not_same_cycle", 69'(bus.l1d_req_valid_o), 69'(0));
      step();
      bus.wakeup_refill_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("replay_valid", 69'(bus.l1d_req_valid_o), 69'(1));
         step();
      end
      @(negedge clk);
      chk("replay_done", 69'(bus.l1d_req_valid_o), 69'(0));
      step();
      respond(1, LSU_LD, 1);
      respond(2, LSU_LD, 1);
      respond(4, LSU_LD, 1);

      // sleep on MSHR-full together with mshr_avail goes straight to PENDING
      issue(7, 40'h700);
      bus.sleep_valid_i = 1'b1; bus.sleep_lsu_id_i = 5'd7;
      bus.sleep_mshr_full_i = 1'b1; bus.wakeup_mshr_avail_i = 1'b1;
      @(negedge clk);
      chk("full_avail_no_issue", 69'(bus.l1d_req_valid_o), 69'(0));
      step();
      bus.sleep_valid_i = 1'b0; bus.sleep_mshr_full_i = 1'b0; bus.wakeup_mshr_avail_i = 1'b0;
      q_req.push_back({5'd7, 40'h700});
      @(negedge clk);
      chk("full_avail_reissue", 69'(bus.l1d_req_valid_o), 69'(1));
      step();
      respond(7, LSU_LD, 1);

      // an AMO response with a live tag passes through without freeing
      issue(20, 40'h1400);
      respond(20, LSU_AMOADDW, 1);
      @(negedge clk);
      chk("amo_no_match_occ", 69'(bus.occupancy_o), 69'(1));
      step();
      respond(20, LSU_LD, 1);
      @(negedge clk);
      chk("amo_then_free_occ", 69'(bus.occupancy_o), 69'(0));
      step();

      // fill all 32 entries
      for (int i = 0; i < 32; i++) issue(i, 40'(i * 64));
      @(negedge clk);
      chk("full_ready", 69'(bus.core_req_ready_o), 69'(0));
      chk("full_occ", 69'(bus.occupancy_o), 69'(32));
      step();
      req_on(9, 40'hBEEF);
      @(negedge clk);
      chk("full_no_issue", 69'(bus.l1d_req_valid_o), 69'(0));
      step();
      bus.core_req_valid_i = 1'b0;
      bus.l1d_resp_valid_i = 1'b1; bus.l1d_resp_i.lsu_id = 5'd0;
      bus.l1d_resp_i.req_type = LSU_LD; bus.l1d_resp_i.ld_data = 64'hD000_0000;
      q_resp.push_back({5'd0, 64'hD000_0000});
      @(negedge clk);
      chk("ready_same_cycle", 69'(bus.core_req_ready_o), 69'(0));
      step();
      bus.l1d_resp_valid_i = 1'b0;
      @(negedge clk);
      chk("ready_next_cycle", 69'(bus.core_req_ready_o), 69'(1));
      step();
      for (int i = 1; i < 32; i++) respond(i, LSU_LD, 1);

      // flush with 2 SENT and 3 IDMISS entries
      issue(10, 40'hA00);
      issue(11, 40'hB00);
      issue(12, 40'hC00);
      issue(13, 40'hD00);
      issue(14, 40'hE00);
      sleep(12, 1'b0, 2'd1);
      sleep(13, 1'b0, 2'd1);
      sleep(14, 1'b0, 2'd1);
      @(negedge clk);
      chk("pre_flush_occ", 69'(bus.occupancy_o), 69'(5));
      step();
      bus.flush_i = 1'b1;
      @(negedge clk);
      chk("flush_blocks_ready", 69'(bus.core_req_ready_o), 69'(0));
      step();
      bus.flush_i = 1'b0;
      @(negedge clk);
      chk("post_flush_occ", 69'(bus.occupancy_o), 69'(2));
      step();
      respond(10, LSU_LD, 0);
      respond(11, LSU_LD, 0);
      @(negedge clk);
      chk("flushed_freed_occ", 69'(bus.occupancy_o), 69'(0));
      step();
      bus.wakeup_refill_valid_i = 1'b1; bus.wakeup_mshr_id_i = 2'd1;
      @(negedge clk);
      chk("flushed_no_replay", 69'(bus.l1d_req_valid_o), 69'(0));
      step();
      bus.wakeup_refill_valid_i = 1'b0;
      @(negedge clk);
      chk("flushed_no_replay_next", 69'(bus.l1d_req_valid_o), 69'(0));
      step();

      chk("req_queue_drained", 69'(q_req.size()), 69'(0));
      chk("resp_queue_drained", 69'(q_resp.size()), 69'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
